// File: rtl/intl_reg_fault_detect_pkg.sv
// intl_pkg: shared types and constants for the interlock fault detector.
//   state_t      : FSM encoding, also driven out on o_state for status readback
//   DW_DEF       : default data/setpoint width
//   CNT_SAT_FILL : bit value that fills a saturated persistence counter
// Optional feature macro used elsewhere in this slice: INTL_FAULT_CAPTURE_EN.
package intl_pkg;

    localparam int DW_DEF = 32;

    // A persistence counter saturates at all-ones; it never wraps back to 0.
    localparam logic CNT_SAT_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ARMED = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/intl_reg_fault_detect_if.sv
// intl_reg_fault_detect_if: measurement, setpoint and status bundle of one
// interlock channel.
//   master : producer of enable/clear, samples and setpoints; reads the flags
//   slave  : the detector
// With INTL_FAULT_CAPTURE_EN defined the bundle also carries o_fault_data.
interface intl_reg_fault_detect_if #(
    parameter int DW = intl_pkg::DW_DEF
);
    logic          i_en;
    logic          i_clr;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic [DW-1:0] i_ref;
    logic [DW-1:0] i_data_thresh;
    logic [DW-1:0] i_cnt_thresh;
    logic [DW-1:0] i_period;
    logic [DW-1:0] i_cycle_cnt;
    logic [DW-1:0] i_diff;
    logic [DW-1:0] i_delay;
    logic          o_over_intl;
    logic          o_osc_intl;
    logic          o_intl;
    logic [1:0]    o_state;
`ifdef INTL_FAULT_CAPTURE_EN
    logic [DW-1:0] o_fault_data;
`endif

    modport master (
        output i_en, i_clr, i_data, i_data_valid, i_ref, i_data_thresh,
               i_cnt_thresh, i_period, i_cycle_cnt, i_diff, i_delay,
`ifdef INTL_FAULT_CAPTURE_EN
        input  o_fault_data,
`endif
        input  o_over_intl, o_osc_intl, o_intl, o_state
    );

    modport slave (
        input  i_en, i_clr, i_data, i_data_valid, i_ref, i_data_thresh,
               i_cnt_thresh, i_period, i_cycle_cnt, i_diff, i_delay,
`ifdef INTL_FAULT_CAPTURE_EN
        output o_fault_data,
`endif
        output o_over_intl, o_osc_intl, o_intl, o_state
    );

endinterface

// File: rtl/intl_reg_fault_detect_persist_cnt.sv
// intl_persist_cnt: saturating consecutive-event counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over step)
//   step       : an observation happens this cycle
//   inc        : the observation is an event (count up) or not (restart at 0)
//   thresh     : trip level, 0 disables tripping
//   trip       : updated count reaches thresh on this step (combinational)
module intl_persist_cnt
    import intl_pkg::*;
#(
    parameter int W = DW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    input  logic         inc,
    input  logic [W-1:0] thresh,
    output logic         trip
);
    localparam logic [W-1:0] SAT = {W{CNT_SAT_FILL}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_upd;

    always_comb begin
        cnt_upd = '0;
        if (inc) begin
            cnt_upd = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;
        end
    end

    assign trip = step && !clr && (thresh != '0) && (cnt_upd >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_upd;
        end
    end

endmodule

// File: rtl/intl_reg_fault_detect.sv
// intl_reg_fault_detect: per-channel interlock detector (C or V channel).
// Detects a sustained over-threshold excursion and persistent regulation
// deviation, latching a fault flag until software clears it from FAULT.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : enable/clear, samples, setpoints, latched flags, state
// Optional: INTL_FAULT_CAPTURE_EN adds o_fault_data (sample that caused trip).
//
// state | meaning
// IDLE  | power stage off, nothing monitored
// DELAY | blanking after enable, counts up to i_delay
// ARMED | excursion and deviation checks running
// FAULT | latch(es) set, held until i_clr
module intl_reg_fault_detect
    import intl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input logic               i_clk,
    input logic               i_rst_n,
    intl_reg_fault_detect_if.slave bus
);
    state_t state, state_nxt;

    logic [DW-1:0] dly_cnt;
    logic [DW-1:0] win_cnt;
    logic          dev_flag;
    logic          over_q, osc_q, intl_q;
    logic          over_nxt, osc_nxt;

    logic signed [DW:0] data_x, ref_x, diff_s;
    logic [DW:0]        data_abs, diff_abs;
    logic               armed_act, over_hit, dev_hit, dev_seen, win_end;
    logic               over_trip, osc_trip;

    // One extra bit so abs(-2^(DW-1)) and data-ref never overflow.
    always_comb begin
        data_x   = {bus.i_data[DW-1], bus.i_data};
        ref_x    = {bus.i_ref[DW-1], bus.i_ref};
        diff_s   = data_x - ref_x;
        data_abs = data_x[DW] ? -data_x : data_x;
        diff_abs = diff_s[DW] ? -diff_s : diff_s;
    end

    // A cycle that leaves ARMED (i_en low) or carries i_clr only clears.
    assign armed_act = (state == ARMED) && bus.i_en && !bus.i_clr;
    assign over_hit  = data_abs > {1'b0, bus.i_data_thresh};
    assign dev_hit   = bus.i_data_valid && (diff_abs > {1'b0, bus.i_diff});
    assign dev_seen  = dev_flag | dev_hit;
    // >= so a shrinking i_period mid-window still closes the window.
    assign win_end   = (bus.i_period != '0) && (win_cnt >= bus.i_period - 1'b1);

    intl_persist_cnt #(.W(DW)) u_run_cnt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (!armed_act),
        .step   (armed_act && bus.i_data_valid),
        .inc    (over_hit),
        .thresh (bus.i_cnt_thresh),
        .trip   (over_trip)
    );

    intl_persist_cnt #(.W(DW)) u_cyc_cnt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (!armed_act),
        .step   (armed_act && win_end),
        .inc    (dev_seen),
        .thresh (bus.i_cycle_cnt),
        .trip   (osc_trip)
    );

    always_comb begin
        state_nxt = state;
        over_nxt  = over_q | over_trip;
        osc_nxt   = osc_q | osc_trip;
        case (state)
            IDLE:  if (bus.i_en) state_nxt = DELAY;
            DELAY: begin
                if (!bus.i_en)                    state_nxt = IDLE;
                else if (dly_cnt >= bus.i_delay)  state_nxt = ARMED;
            end
            ARMED: begin
                if (!bus.i_en)                    state_nxt = IDLE;
                else if (over_trip || osc_trip)   state_nxt = FAULT;
            end
            FAULT: begin
                if (bus.i_clr) begin
                    state_nxt = IDLE;
                    over_nxt  = 1'b0;
                    osc_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            over_q <= 1'b0;
            osc_q  <= 1'b0;
            intl_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            over_q <= over_nxt;
            osc_q  <= osc_nxt;
            intl_q <= over_nxt | osc_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dly_cnt  <= '0;
            win_cnt  <= '0;
            dev_flag <= 1'b0;
        end else begin
            if (state == DELAY && state_nxt == DELAY && !bus.i_clr)
                dly_cnt <= dly_cnt + 1'b1;
            else
                dly_cnt <= '0;

            if (!armed_act || bus.i_period == '0) begin
                win_cnt  <= '0;
                dev_flag <= 1'b0;
            end else if (win_end) begin
                win_cnt  <= '0;
                dev_flag <= 1'b0;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                dev_flag <= dev_seen;
            end
        end
    end

`ifdef INTL_FAULT_CAPTURE_EN
    logic [DW-1:0] last_dev;
    logic [DW-1:0] fault_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_dev     <= '0;
            fault_data_q <= '0;
        end else begin
            if (!armed_act)   last_dev <= '0;
            else if (dev_hit) last_dev <= bus.i_data;

            // Excursion wins on a simultaneous trip.
            if (state == FAULT && bus.i_clr)
                fault_data_q <= '0;
            else if (over_trip)
                fault_data_q <= bus.i_data;
            else if (osc_trip)
                fault_data_q <= dev_hit ? bus.i_data : last_dev;
        end
    end

    assign bus.o_fault_data = fault_data_q;
`endif

    assign bus.o_over_intl = over_q;
    assign bus.o_osc_intl  = osc_q;
    assign bus.o_intl      = intl_q;
    assign bus.o_state     = state;

endmodule

// File: tb/tb_intl_reg_fault_detect.sv
module tb_intl_reg_fault_detect;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    intl_reg_fault_detect_if #(.DW(32)) bus ();

    intl_reg_fault_detect #(.DW(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_window(input bit dev);
        for (int k = 0; k < 10; k++) begin
            bus.i_data       = (dev && k == 3) ? 32'd80 : 32'd0;
            bus.i_data_valid = 1'b1;
            tick();
        end
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_en = 0; bus.i_clr = 0; bus.i_data = '0; bus.i_data_valid = 0;
        bus.i_ref = '0; bus.i_data_thresh = '0; bus.i_cnt_thresh = '0;
        bus.i_period = '0; bus.i_cycle_cnt = '0; bus.i_diff = '0; bus.i_delay = '0;
        tick();
        tick();
        check("rst_state", 64'(bus.o_state), 64'd0);
        check("rst_over", 64'(bus.o_over_intl), 64'd0);
        check("rst_osc", 64'(bus.o_osc_intl), 64'd0);
        check("rst_intl", 64'(bus.o_intl), 64'd0);
`ifdef INTL_FAULT_CAPTURE_EN
        check("rst_fault_data", 64'(bus.o_fault_data), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Blanking: 101 cycles in DELAY, over-threshold sample there ignored.
        bus.i_delay = 32'd100; bus.i_data_thresh = 32'd1000; bus.i_cnt_thresh = 32'd1;
        bus.i_en = 1'b1;
        tick();
        n = 0;
        while (bus.o_state == 2'd1 && n < 300) begin
            n++;
            bus.i_data_valid = (n == 50);
            bus.i_data       = (n == 50) ? 32'd5000 : 32'd0;
            tick();
        end
        bus.i_data_valid = 1'b0;
        check("delay_cycles", 64'(n), 64'd101);
        check("delay_armed", 64'(bus.o_state), 64'd2);
        check("delay_no_trip", 64'(bus.o_over_intl), 64'd0);

        // Excursion: broken run does not trip.
        bus.i_cnt_thresh = 32'd3;
        bus.i_data_valid = 1'b1;
        bus.i_data = 32'd1200; tick();
        bus.i_data = 32'd900;  tick();
        bus.i_data = 32'd1200; tick();
        bus.i_data = 32'd1200; tick();
        check("run_broken_over", 64'(bus.o_over_intl), 64'd0);
        check("run_broken_state", 64'(bus.o_state), 64'd2);
        bus.i_data = 32'd0; tick();
        bus.i_data = 32'd1200; tick();
        bus.i_data = 32'(-1500); tick();
        check("run_two_over", 64'(bus.o_over_intl), 64'd0);
        bus.i_data = 32'd1100; tick();
        bus.i_data_valid = 1'b0;
        check("run_trip_over", 64'(bus.o_over_intl), 64'd1);
        check("run_trip_state", 64'(bus.o_state), 64'd3);
        check("run_trip_intl", 64'(bus.o_intl), 64'd1);
        check("run_trip_osc", 64'(bus.o_osc_intl), 64'd0);
`ifdef INTL_FAULT_CAPTURE_EN
        check("run_fault_data", 64'(bus.o_fault_data), 64'h0000_044C);
`endif

        // FAULT holds through i_en=0, i_clr releases.
        bus.i_en = 1'b0;
        tick(); tick();
        check("fault_hold_state", 64'(bus.o_state), 64'd3);
        check("fault_hold_intl", 64'(bus.o_intl), 64'd1);
        bus.i_clr = 1'b1; tick(); bus.i_clr = 1'b0;
        check("clr_state", 64'(bus.o_state), 64'd0);
        check("clr_over", 64'(bus.o_over_intl), 64'd0);
        check("clr_intl", 64'(bus.o_intl), 64'd0);
`ifdef INTL_FAULT_CAPTURE_EN
        check("clr_fault_data", 64'(bus.o_fault_data), 64'd0);
`endif

        // Deviation: windows dev, clean, dev -> no trip; one more dev -> trip.
        bus.i_cnt_thresh = '0; bus.i_period = 32'd10; bus.i_diff = 32'd50;
        bus.i_ref = '0; bus.i_cycle_cnt = 32'd2; bus.i_delay = '0;
        bus.i_en = 1'b1;
        tick(); tick();
        check("osc_armed", 64'(bus.o_state), 64'd2);
        run_window(1'b1);
        check("osc_win1", 64'(bus.o_osc_intl), 64'd0);
        run_window(1'b0);
        run_window(1'b1);
        check("osc_clean_reset", 64'(bus.o_osc_intl), 64'd0);
        check("osc_clean_state", 64'(bus.o_state), 64'd2);
        run_window(1'b1);
        check("osc_trip", 64'(bus.o_osc_intl), 64'd1);
        check("osc_trip_over", 64'(bus.o_over_intl), 64'd0);
        check("osc_trip_state", 64'(bus.o_state), 64'd3);
        check("osc_trip_intl", 64'(bus.o_intl), 64'd1);
`ifdef INTL_FAULT_CAPTURE_EN
        check("osc_fault_data", 64'(bus.o_fault_data), 64'd80);
`endif
        bus.i_clr = 1'b1; tick(); bus.i_clr = 1'b0;
        check("osc_clr_state", 64'(bus.o_state), 64'd0);
        check("osc_clr_osc", 64'(bus.o_osc_intl), 64'd0);
        bus.i_en = 1'b0;
        tick();

        // Most negative sample against the largest positive limit.
        bus.i_period = '0; bus.i_cycle_cnt = '0;
        bus.i_data_thresh = 32'h7FFF_FFFF; bus.i_cnt_thresh = 32'd1;
        bus.i_en = 1'b1;
        tick(); tick();
        check("min_armed", 64'(bus.o_state), 64'd2);
        bus.i_data = 32'h8000_0000; bus.i_data_valid = 1'b1;
        tick();
        bus.i_data_valid = 1'b0;
        check("min_trip_over", 64'(bus.o_over_intl), 64'd1);
        check("min_trip_state", 64'(bus.o_state), 64'd3);
`ifdef INTL_FAULT_CAPTURE_EN
        check("min_fault_data", 64'(bus.o_fault_data), 64'h8000_0000);
`endif
        bus.i_clr = 1'b1; tick(); bus.i_clr = 1'b0;

        // Asynchronous reset while ARMED.
        bus.i_cnt_thresh = '0; bus.i_data = '0;
        tick(); tick();
        check("async_pre_state", 64'(bus.o_state), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        check("async_state", 64'(bus.o_state), 64'd0);
        check("async_intl", 64'(bus.o_intl), 64'd0);
        tick();
        rst_n = 1'b1;

        // Both checks disabled: extreme data for 1000 cycles never trips.
        bus.i_period = 32'd10; bus.i_diff = '0; bus.i_cycle_cnt = '0;
        bus.i_cnt_thresh = '0; bus.i_data_thresh = 32'd1000;
        tick(); tick();
        check("dis_armed", 64'(bus.o_state), 64'd2);
        bus.i_data_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            bus.i_data = k[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
            tick();
        end
        check("dis_state", 64'(bus.o_state), 64'd2);
        check("dis_intl", 64'(bus.o_intl), 64'd0);

        bus.i_cnt_thresh = 32'd1; bus.i_data = 32'd1500;
        tick();
        bus.i_data_valid = 1'b0;
        check("cap_trip_over", 64'(bus.o_over_intl), 64'd1);
        check("cap_trip_osc", 64'(bus.o_osc_intl), 64'd0);
`ifdef INTL_FAULT_CAPTURE_EN
        check("cap_fault_data", 64'(bus.o_fault_data), 64'd1500);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
